// File: rtl/time_report_tx_pkg.sv
// ---------------------------------------------------------------------------
// time_report_tx_pkg
// Shared definitions for the time-report UART transmitter:
//   - ASCII constants used to build the "HH:MM:SS\r\n" line
//   - bit-level transmitter state encoding
//   - packed type holding the six zero-extended BCD digits
//   - helpers: baud divisor, digit-to-ASCII mapping, byte selection by index
// ---------------------------------------------------------------------------
package time_report_tx_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int LINE_BYTES = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Index 0 = hour_high ... index 5 = second_low, each zero-extended to 4 bits.
    typedef logic [5:0][3:0] digits_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Anything that is not a valid BCD digit is shown as '?'.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_QMARK;
    endfunction

    function automatic logic [7:0] line_byte(input logic [3:0] idx, input digits_t d);
        logic [7:0] b;
        case (idx)
            4'd0:    b = digit_ascii(d[0]);
            4'd1:    b = digit_ascii(d[1]);
            4'd2:    b = ASCII_COLON;
            4'd3:    b = digit_ascii(d[2]);
            4'd4:    b = digit_ascii(d[3]);
            4'd5:    b = ASCII_COLON;
            4'd6:    b = digit_ascii(d[4]);
            4'd7:    b = digit_ascii(d[5]);
            4'd8:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/time_report_tx_if.sv
// ---------------------------------------------------------------------------
// time_report_tx_if
// Groups the request/enable, the six BCD digit buses and the UART status
// outputs of the time-report transmitter.
//   master : drives ena, send and the digits; observes tx, busy, done
//   slave  : the transmitter side
// ---------------------------------------------------------------------------
interface time_report_tx_if;
    logic       ena;
    logic       send;
    logic [1:0] hour_high;
    logic [3:0] hour_low;
    logic [2:0] minute_high;
    logic [3:0] minute_low;
    logic [2:0] second_high;
    logic [3:0] second_low;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output ena, send, hour_high, hour_low, minute_high, minute_low,
               second_high, second_low,
        input  tx, busy, done
    );

    modport slave (
        input  ena, send, hour_high, hour_low, minute_high, minute_low,
               second_high, second_low,
        output tx, busy, done
    );
endinterface

// File: rtl/time_report_tx_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// time_report_tx_uart_tx_byte
// 8N1 byte serialiser, LSB first. Each start/data/stop bit is held for
// exactly CLKS_PER_BIT cycles.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   load_i        accept data_i (honoured only while ready_o is high)
//   data_i[7:0]   byte to send
//   ready_o       high in IDLE and in the last cycle of a stop bit, so a new
//                 byte can follow the previous one with no idle gap
//   tx_o          registered serial output, idles high
// ---------------------------------------------------------------------------
module time_report_tx_uart_tx_byte
    import time_report_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign tx_o    = tx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_o = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
                if (load_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                end
            end
            ST_START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    // 3-bit index wraps 7 -> 0 on its own
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    ready_o = 1'b1;
                    if (load_i) begin
                        state_d = ST_START;
                        shift_d = data_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output derived from the next state so tx changes on the same edge
        // as the state and needs no extra cycle of latency.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/time_report_tx.sv
// ---------------------------------------------------------------------------
// time_report_tx
// Sends the current time as the 10-byte ASCII line "HH:MM:SS\r\n" over a
// UART (8N1, LSB first).
// Ports:
//   CLK_100M  system clock
//   rst       asynchronous, active-high reset (tx returns high at once)
//   bus       time_report_tx_if.slave:
//               ena, send          enable and one-cycle send request
//               hour_high..second_low  BCD digits, snapshotted on accept
//               tx                 serial line, idles high
//               busy               high while a line is in flight
//               done               one-cycle pulse after a complete line
// A request is accepted only when idle; the digits are captured on that
// edge. Dropping ena mid-line lets the current byte finish and then
// abandons the line without a done pulse.
// ---------------------------------------------------------------------------
module time_report_tx
    import time_report_tx_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic              CLK_100M,
    input  logic              rst,
    time_report_tx_if.slave   bus
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [3:0] LAST_IDX     = 4'(LINE_BYTES - 1);

    digits_t    live_digits;
    digits_t    snap_q, snap_d;
    logic [3:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       u_load;
    logic [7:0] u_data;
    logic       u_ready;
    logic       u_tx;

    logic       start_req;
    logic       byte_end;

    assign live_digits = {bus.second_low,
                          {1'b0, bus.second_high},
                          bus.minute_low,
                          {1'b0, bus.minute_high},
                          bus.hour_low,
                          {2'b00, bus.hour_high}};

    assign start_req = bus.send && bus.ena && !busy_q;
    // While a line is in flight the serialiser is never idle, so ready
    // means "last cycle of the current stop bit".
    assign byte_end  = busy_q && u_ready;

    always_ff @(posedge CLK_100M or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        snap_d = snap_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        u_load = 1'b0;
        u_data = 8'h00;

        if (start_req) begin
            // Byte 0 comes from the live inputs because the snapshot is
            // written on this very edge.
            snap_d = live_digits;
            idx_d  = '0;
            busy_d = 1'b1;
            u_load = 1'b1;
            u_data = line_byte(4'd0, live_digits);
        end else if (byte_end) begin
            if (idx_q == LAST_IDX) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                idx_d  = '0;
            end else if (!bus.ena) begin
                busy_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + 4'd1;
                u_load = 1'b1;
                u_data = line_byte(idx_q + 4'd1, snap_q);
            end
        end
    end

    time_report_tx_uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk_i   (CLK_100M),
        .rst_i   (rst),
        .load_i  (u_load),
        .data_i  (u_data),
        .ready_o (u_ready),
        .tx_o    (u_tx)
    );

    assign bus.tx   = u_tx;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
